// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte producers.
// It issues one byte at a time and waits for the transmitter's TC flag to fall and rise again.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_bar,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_write_enable,
    input  logic                 tx_complete,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [7:0]    count;

    logic          found;
    logic [PW-1:0] winner;
    logic [PW-1:0] winner_next;
    logic [IW-1:0] idx;

    // Scan downward in offset so the requester closest to ptr wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(NUM_REQ))
                idx = idx - IW'(NUM_REQ);
            if (req[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
        winner_next = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state           <= IDLE;
            ptr             <= '0;
            count           <= '0;
            tx_data         <= 8'h00;
            tx_write_enable <= 1'b0;
            grant_ack       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            tx_write_enable <= 1'b0;
            grant_ack       <= '0;
            timeout_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_complete && found) begin
                        tx_data         <= req_data[int'(winner)*8 +: 8];
                        tx_write_enable <= 1'b1;
                        grant_ack       <= NUM_REQ'(1) << winner;
                        ptr             <= winner_next;
                        count           <= 8'd0;
                        state           <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    // Give up if the transmitter never reports that it started shifting.
                    if (!tx_complete) begin
                        state <= WAIT_HIGH;
                    end else if (count == 8'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (tx_complete)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transaction-level reference checked every cycle,
// plus directed scenarios with hand-computed grant orders and timings.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_bar = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  grant_ack;
    logic [7:0]  tx_data;
    logic        tx_write_enable;
    logic        tx_complete;
    logic        busy;
    logic        timeout_err;

    bit   uart_auto = 1'b1;
    logic tc_uart   = 1'b1;
    logic tc_manual = 1'b1;
    int   uart_len  = 3;

    assign tx_complete = uart_auto ? tc_uart : tc_manual;

    int checks = 0;
    int passed = 0;

    logic [3:0] exp_ack  = 4'b0;
    logic [7:0] exp_data = 8'h00;
    bit         exp_we   = 1'b0;
    bit         exp_busy = 1'b0;
    bit         exp_terr = 1'b0;
    int         m_ptr    = 0;
    bit         aborted  = 1'b0;

    int         log_w[$];
    logic [7:0] log_d[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset_bar       (reset_bar),
        .req             (req),
        .req_data        (req_data),
        .grant_ack       (grant_ack),
        .tx_data         (tx_data),
        .tx_write_enable (tx_write_enable),
        .tx_complete     (tx_complete),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N])
                return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk or negedge reset_bar);
        aborted = (reset_bar == 1'b0);
    endtask

    // Reference model: one transaction per loop pass, expectations describe the next cycle.
    initial begin : model
        int w;
        int edges;
        bit low_seen;
        forever begin
            if (!reset_bar) begin
                exp_ack = 4'b0; exp_data = 8'h00; exp_we = 1'b0;
                exp_busy = 1'b0; exp_terr = 1'b0; m_ptr = 0;
                wait (reset_bar);
            end
            tick();
            if (aborted) continue;
            exp_we = 1'b0; exp_ack = 4'b0; exp_terr = 1'b0;
            if (tx_complete && req != 4'b0) begin
                w        = pick(req, m_ptr);
                m_ptr    = (w + 1) % N;
                exp_we   = 1'b1;
                exp_ack  = 4'(1 << w);
                exp_data = req_data[8*w +: 8];
                exp_busy = 1'b1;
                edges    = 0;
                low_seen = 1'b0;
                while (!low_seen) begin
                    tick();
                    if (aborted) break;
                    exp_we = 1'b0; exp_ack = 4'b0;
                    edges++;
                    if (!tx_complete)
                        low_seen = 1'b1;
                    else if (edges == TO + 1) begin
                        exp_terr = 1'b1;
                        exp_busy = 1'b0;
                        break;
                    end
                end
                if (low_seen) begin
                    do begin
                        tick();
                        if (aborted) break;
                    end while (!tx_complete);
                    if (!aborted) exp_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check_output("cycle {terr,busy,we,ack,data}",
                     {17'b0, exp_terr, exp_busy, exp_we, exp_ack, exp_data},
                     {17'b0, timeout_err, busy, tx_write_enable, grant_ack, tx_data});
        if (grant_ack != 4'b0) begin
            int gi;
            gi = 0;
            check_output("ack onehot", $countones(grant_ack), 1);
            for (int i = 0; i < N; i++)
                if (grant_ack[i]) gi = i;
            log_w.push_back(gi);
            log_d.push_back(tx_data);
        end
    end

    // Transmitter stand-in: TC drops after each strobe for uart_len cycles.
    initial begin : uart_model
        forever begin
            @(posedge clk);
            if (tx_write_enable) begin
                #1 tc_uart = 1'b0;
                repeat (uart_len) @(posedge clk);
                #1 tc_uart = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] d);
        @(posedge clk);
        #1;
        req      = r;
        req_data = d;
    endtask

    task automatic drop_req(input logic [3:0] r);
        @(posedge clk);
        #1 req = r;
    endtask

    task automatic wait_grants(input int n);
        int t;
        t = 0;
        while (log_w.size() < n && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (log_w.size() < n)
            check_output("grant wait expired", log_w.size(), n);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy)
            check_output("idle wait expired", busy, 0);
    endtask

    task automatic clear_log();
        log_w.delete();
        log_d.delete();
    endtask

    initial begin : stimulus
        int bc;
        int n;
        int exp_cw[5];
        logic [7:0] exp_cd[5];
        int exp_fw[3];
        logic [7:0] exp_fd[3];

        // Reset state
        #12;
        check_output("reset tx_data", tx_data, 8'h00);
        check_output("reset we", tx_write_enable, 0);
        check_output("reset ack", grant_ack, 4'b0);
        check_output("reset busy", busy, 0);
        @(posedge clk);
        #1 reset_bar = 1'b1;

        // Single requester with a 10-cycle transmitter
        uart_len = 10;
        clear_log();
        apply_stimulus(4'b0100, 32'h00A5_0000);
        @(negedge clk);
        @(negedge clk);
        check_output("single tx_data", tx_data, 8'hA5);
        check_output("single we", tx_write_enable, 1);
        check_output("single ack", grant_ack, 4'b0100);
        drop_req(4'b0000);
        bc = 1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
        end
        check_output("single busy cycles", bc, 12);
        check_output("single we after", tx_write_enable, 0);

        // Reset asserted while waiting for TC to rise
        clear_log();
        apply_stimulus(4'b0010, 32'h0000_3C00);
        wait_grants(1);
        drop_req(4'b0000);
        repeat (4) @(posedge clk);
        #2;
        check_output("pre-reset busy", busy, 1);
        reset_bar = 1'b0;
        #1;
        check_output("mid reset tx_data", tx_data, 8'h00);
        check_output("mid reset busy", busy, 0);
        check_output("mid reset we", tx_write_enable, 0);
        check_output("mid reset ack", grant_ack, 4'b0);
        check_output("mid reset terr", timeout_err, 0);
        for (int t = 0; t < 30 && tc_uart !== 1'b1; t++) @(posedge clk);
        @(posedge clk);
        #1 reset_bar = 1'b1;

        // Contention: all four pending
        uart_len = 3;
        clear_log();
        exp_cw = '{0, 1, 2, 3, 0};
        exp_cd = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        apply_stimulus(4'b1111, 32'h1312_1110);
        wait_grants(5);
        drop_req(4'b0000);
        wait_idle();
        check_output("contention count", log_w.size(), 5);
        for (int i = 0; i < 5 && i < log_w.size(); i++) begin
            check_output($sformatf("contention winner %0d", i), log_w[i], exp_cw[i]);
            check_output($sformatf("contention data %0d", i), log_d[i], exp_cd[i]);
        end

        // Fairness with gaps after a fresh reset
        @(posedge clk);
        #1 reset_bar = 1'b0;
        @(posedge clk);
        #1 reset_bar = 1'b1;
        clear_log();
        exp_fw = '{1, 3, 1};
        exp_fd = '{8'hB1, 8'hB3, 8'hB1};
        apply_stimulus(4'b1010, 32'hB3B2_B1B0);
        wait_grants(3);
        drop_req(4'b0000);
        wait_idle();
        check_output("fairness count", log_w.size(), 3);
        for (int i = 0; i < 3 && i < log_w.size(); i++) begin
            check_output($sformatf("fairness winner %0d", i), log_w[i], exp_fw[i]);
            check_output($sformatf("fairness data %0d", i), log_d[i], exp_fd[i]);
        end

        // Hold-off while TC is low in IDLE
        clear_log();
        @(posedge clk);
        #1;
        tc_manual = 1'b0;
        uart_auto = 1'b0;
        req       = 4'b0001;
        req_data  = 32'h0000_005C;
        repeat (6) @(negedge clk);
        check_output("holdoff no grant", log_w.size(), 0);
        check_output("holdoff busy", busy, 0);
        @(posedge clk);
        #1 tc_manual = 1'b1;
        @(negedge clk);
        check_output("holdoff we same cycle", tx_write_enable, 0);
        @(negedge clk);
        check_output("holdoff we", tx_write_enable, 1);
        check_output("holdoff ack", grant_ack, 4'b0001);
        check_output("holdoff tx_data", tx_data, 8'h5C);
        @(posedge clk);
        #1;
        req       = 4'b0000;
        tc_manual = 1'b0;
        repeat (3) @(posedge clk);
        #1 tc_manual = 1'b1;
        wait_idle();

        // Timeout: TC never falls
        clear_log();
        apply_stimulus(4'b1010, 32'h8800_7700);
        wait_grants(1);
        if (log_w.size() > 0)
            check_output("timeout first winner", log_w[0], 1);
        drop_req(4'b1000);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        check_output("timeout delay", n, 16);
        check_output("timeout busy", busy, 0);
        @(negedge clk);
        check_output("after timeout we", tx_write_enable, 1);
        check_output("after timeout ack", grant_ack, 4'b1000);
        check_output("after timeout tx_data", tx_data, 8'h88);
        drop_req(4'b0000);
        wait_idle();

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
